// File: rtl/pcie_lcrc_stream_checker.sv
// -----------------------------------------------------------------------------
// pcie_lcrc_stream_checker
//
// Streaming LCRC checker for the DLL RX path. A TLP arrives DATA_W bits per
// clock (sop/eop framed, partial final beat via s_nbytes_i). A 32-bit CRC is
// accumulated bit-serially (bit 0 of each beat first, whole beat unrolled in
// one cycle) and compared on the eop beat against the received LCRC. One
// registered result per packet is returned over a valid/ready handshake.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   s_valid_i    input beat valid          s_ready_o   checker accepts beat
//   s_sop_i      first beat of packet      s_eop_i     last beat of packet
//   s_data_i     payload beat              s_nbytes_i  valid bytes on eop beat
//   crc_i        received LCRC (sampled on accepted eop beat)
//   res_valid_o  result available          res_ready_i result consumed
//   crc_ok_o     CRC matched, no error     crc_calc_o  computed CRC ^ XOROUT
//   len_err_o    packet exceeded MAX_BEATS seq_err_o   framing violation
// -----------------------------------------------------------------------------
module pcie_lcrc_stream_checker #(
  parameter int          DATA_W    = 32,
  parameter logic [31:0] POLY      = 32'h04C11DB7,
  parameter logic [31:0] INIT      = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT    = 32'h00000000,
  parameter int          MAX_BEATS = 8,
  parameter int          NB_W      = $clog2(DATA_W/8) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic              s_sop_i,
  input  logic              s_eop_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic [NB_W-1:0]   s_nbytes_i,
  input  logic [31:0]       crc_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              crc_ok_o,
  output logic [31:0]       crc_calc_o,
  output logic              len_err_o,
  output logic              seq_err_o
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_BEATS + 2);
  // Counter only needs to prove "more than MAX_BEATS", so it parks one above.
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESULT} state_t;

  // Number of data bits to absorb from this beat (only eop beats may be short).
  function automatic int lane_bits(input logic eop, input logic [NB_W-1:0] nb);
    int n;
    int bits;
    n    = int'(nb);
    bits = DATA_W;
    if (eop && n != 0 && n <= NBYTES) bits = 8 * n;
    return bits;
  endfunction

  // Bit-serial CRC over the low nbits of d, bit 0 first, unrolled.
  function automatic logic [31:0] crc_beat(input logic [31:0] seed,
                                           input logic [DATA_W-1:0] d,
                                           input int nbits);
    logic [31:0] c;
    logic        fb;
    c = seed;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < nbits) begin
        fb = c[31] ^ d[i];
        c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_SAT) ? CNT_SAT : c + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic [31:0]        crc_q, crc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               len_q, len_d;       // pending errors of packet in flight
  logic               seq_q, seq_d;
  logic [31:0]        calc_q, calc_d;     // registered result
  logic               ok_q, ok_d;
  logic               len_o_q, len_o_d;
  logic               seq_o_q, seq_o_d;

  logic               accept, restart, orphan, fin, fin_len, fin_seq;
  logic               len_new, seq_new;
  logic [31:0]        seed, crc_new, fin_crc, fin_calc;
  logic [CNT_W-1:0]   cnt_new;

  assign s_ready_o   = (state_q != RESULT);
  assign res_valid_o = (state_q == RESULT);
  assign crc_ok_o    = ok_q;
  assign crc_calc_o  = calc_q;
  assign len_err_o   = len_o_q;
  assign seq_err_o   = seq_o_q;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    seq_d   = seq_q;
    calc_d  = calc_q;
    ok_d    = ok_q;
    len_o_d = len_o_q;
    seq_o_d = seq_o_q;
    fin     = 1'b0;
    fin_crc = INIT;
    fin_len = len_q;
    fin_seq = 1'b1;

    accept  = s_valid_i && s_ready_o;
    // A sop mid-packet abandons the current CRC and starts over.
    restart = (state_q == IDLE) || s_sop_i;
    orphan  = (state_q == IDLE) && !s_sop_i;
    seed    = restart ? INIT : crc_q;
    cnt_new = restart ? CNT_W'(1) : cnt_sat_inc(cnt_q);
    crc_new = crc_beat(seed, s_data_i, lane_bits(s_eop_i, s_nbytes_i));
    len_new = len_q || (cnt_new > CNT_W'(MAX_BEATS));
    seq_new = seq_q || orphan || ((state_q == BUSY) && s_sop_i);

    case (state_q)
      IDLE, BUSY: begin
        if (accept) begin
          seq_d = seq_new;
          if (orphan) begin
            // Beat outside a packet is dropped; an eop still owes a result.
            fin = s_eop_i;
          end else begin
            crc_d   = crc_new;
            cnt_d   = cnt_new;
            len_d   = len_new;
            fin     = s_eop_i;
            fin_crc = crc_new;
            fin_len = len_new;
            fin_seq = seq_new;
            if (!s_eop_i) state_d = BUSY;
          end
        end
      end
      RESULT: begin
        if (res_ready_i) begin
          state_d = IDLE;
          len_d   = 1'b0;
          seq_d   = 1'b0;
          ok_d    = 1'b0;
          len_o_d = 1'b0;
          seq_o_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    fin_calc = fin_crc ^ XOROUT;
    if (fin) begin
      state_d = RESULT;
      calc_d  = fin_calc;
      ok_d    = (fin_calc == crc_i) && !fin_len && !fin_seq;
      len_o_d = fin_len;
      seq_o_d = fin_seq;
    end
  end

  // ---- control / result register stage ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= 1'b0;
      seq_q   <= 1'b0;
      calc_q  <= 32'h0;
      ok_q    <= 1'b0;
      len_o_q <= 1'b0;
      seq_o_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      seq_q   <= seq_d;
      calc_q  <= calc_d;
      ok_q    <= ok_d;
      len_o_q <= len_o_d;
      seq_o_q <= seq_o_d;
    end
  end

  // ---- accumulator stage (reseeded on every packet start, no reset needed) ----
  always_ff @(posedge clk) begin
    crc_q <= crc_d;
    cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_pcie_lcrc_stream_checker.sv
module tb_pcie_lcrc_stream_checker;

  localparam int          DATA_W    = 32;
  localparam int          NB_W      = 3;
  localparam logic [31:0] POLY      = 32'h04C11DB7;
  localparam logic [31:0] INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] XOROUT    = 32'h00000000;
  localparam int          MAX_BEATS = 8;

  logic              clk;
  logic              rst_n;
  logic              s_valid_i, s_ready_o, s_sop_i, s_eop_i;
  logic [DATA_W-1:0] s_data_i;
  logic [NB_W-1:0]   s_nbytes_i;
  logic [31:0]       crc_i;
  logic              res_valid_o, res_ready_i, crc_ok_o, len_err_o, seq_err_o;
  logic [31:0]       crc_calc_o;

  pcie_lcrc_stream_checker #(
    .DATA_W(DATA_W), .POLY(POLY), .INIT(INIT), .XOROUT(XOROUT),
    .MAX_BEATS(MAX_BEATS), .NB_W(NB_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_sop_i(s_sop_i), .s_eop_i(s_eop_i),
    .s_data_i(s_data_i), .s_nbytes_i(s_nbytes_i), .crc_i(crc_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .crc_ok_o(crc_ok_o), .crc_calc_o(crc_calc_o),
    .len_err_o(len_err_o), .seq_err_o(seq_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] calc;
    logic        ok;
    logic        len;
    logic        seq;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    int          nb;
    logic [31:0] crc_in;
    logic [31:0] exp_calc;
    logic        exp_ok;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        expq[$];
  logic [31:0] pkt[16];
  int          rdy_mode = 0;   // 0 always ready, 1 hold low, 2 random
  bit          bubbles  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Golden model: concatenate the packet's valid bits into one stream, then
  // run the textbook bit-serial CRC over it.
  function automatic logic [31:0] ref_pkt(input int nbeats, input int last_nb);
    bit          q[$];
    logic [31:0] c;
    int          nbytes;
    for (int b = 0; b < nbeats; b++) begin
      nbytes = (b == nbeats - 1 && last_nb >= 1 && last_nb <= DATA_W / 8) ? last_nb : DATA_W / 8;
      for (int i = 0; i < 8 * nbytes; i++) q.push_back(pkt[b][i]);
    end
    c = INIT;
    foreach (q[k]) c = (c[31] ^ q[k]) ? ({c[30:0], 1'b0} ^ POLY) : {c[30:0], 1'b0};
    return c ^ XOROUT;
  endfunction

  task automatic push_exp(input logic [31:0] calc, input logic ok, input logic len, input logic seq);
    exp_t e;
    e.calc = calc; e.ok = ok; e.len = len; e.seq = seq;
    expq.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input bit sop, input bit eop, input logic [31:0] d,
                           input int nb, input logic [31:0] crc_in);
    int guard;
    guard      = 0;
    s_valid_i  = 1'b1;
    s_sop_i    = sop;
    s_eop_i    = eop;
    s_data_i   = d;
    s_nbytes_i = NB_W'(nb);
    crc_i      = crc_in;
    while (!s_ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL ready_timeout: s_ready_o stuck at %b, required 1", s_ready_o);
    end
    @(negedge clk);
    s_valid_i = 1'b0;
    s_sop_i   = 1'b0;
    s_eop_i   = 1'b0;
    s_data_i  = $urandom;
  endtask

  task automatic send_pkt(input int nbeats, input int last_nb, input logic [31:0] crc_in);
    for (int b = 0; b < nbeats; b++) begin
      if (bubbles && b > 0 && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      send_beat(b == 0, b == nbeats - 1, pkt[b], (b == nbeats - 1) ? last_nb : 0, crc_in);
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (expq.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", expq.size());
    end
  endtask

  // Result monitor: drives res_ready_i, scores every handshake, and checks
  // that a stalled result holds still with the input side blocked.
  bit          hold_prev = 0;
  exp_t        snap;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev   = 0;
      res_ready_i = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", {31'h0, res_valid_o}, 32'h1);
        chk("hold_calc", crc_calc_o, snap.calc);
        chk("hold_ok", {31'h0, crc_ok_o}, {31'h0, snap.ok});
        chk("hold_len", {31'h0, len_err_o}, {31'h0, snap.len});
        chk("hold_seq", {31'h0, seq_err_o}, {31'h0, snap.seq});
        chk("hold_ready_low", {31'h0, s_ready_o}, 32'h0);
      end
      case (rdy_mode)
        0:       res_ready_i = 1'b1;
        1:       res_ready_i = 1'b0;
        default: res_ready_i = ($urandom_range(0, 1) == 1);
      endcase
      hold_prev = 0;
      if (res_valid_o && res_ready_i) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: calc %h with no packet outstanding", crc_calc_o);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("res_calc", crc_calc_o, e.calc);
          chk("res_ok", {31'h0, crc_ok_o}, {31'h0, e.ok});
          chk("res_len", {31'h0, len_err_o}, {31'h0, e.len});
          chk("res_seq", {31'h0, seq_err_o}, {31'h0, e.seq});
        end
      end else if (res_valid_o) begin
        hold_prev = 1;
        snap.calc = crc_calc_o; snap.ok = crc_ok_o;
        snap.len  = len_err_o;  snap.seq = seq_err_o;
      end
    end
  end

  vec_t tbl[6];

  initial begin
    logic [31:0] calc;
    int          nb, lnb;
    bit          flip;

    rst_n = 1'b0; res_ready_i = 1'b0;
    s_valid_i = 1'b0; s_sop_i = 1'b0; s_eop_i = 1'b0;
    s_data_i = '0; s_nbytes_i = '0; crc_i = '0;

    // Single-beat vectors; entry 0 is the known CRC of one zero byte.
    tbl[0] = '{data: 32'h0, nb: 1, crc_in: 32'h4E08BFB4, exp_calc: 32'h4E08BFB4, exp_ok: 1'b1};
    for (int i = 1; i < 6; i++) begin
      tbl[i].data = $urandom;
      tbl[i].nb   = (i == 1) ? 0 : (i == 2) ? 4 : (i == 3) ? 5 : (i == 4) ? 3 : 7;
      pkt[0]      = tbl[i].data;
      calc        = ref_pkt(1, tbl[i].nb);
      tbl[i].exp_calc = calc;
      tbl[i].exp_ok   = (i % 2 == 1);
      tbl[i].crc_in   = tbl[i].exp_ok ? calc : calc ^ 32'h8000_0000;
    end

    repeat (3) @(negedge clk);
    chk("rst_valid", {31'h0, res_valid_o}, 32'h0);
    chk("rst_ready", {31'h0, s_ready_o}, 32'h1);
    chk("rst_calc", crc_calc_o, 32'h0);
    chk("rst_ok", {31'h0, crc_ok_o}, 32'h0);
    chk("rst_len", {31'h0, len_err_o}, 32'h0);
    chk("rst_seq", {31'h0, seq_err_o}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    rdy_mode = 0;
    for (int i = 0; i < 6; i++) begin
      pkt[0] = tbl[i].data;
      push_exp(tbl[i].exp_calc, tbl[i].exp_ok, 1'b0, 1'b0);
      send_pkt(1, tbl[i].nb, tbl[i].crc_in);
      chk("latency_valid", {31'h0, res_valid_o}, 32'h1);
    end
    wait_drain();

    // 7-beat (224-bit) packet, good then with crc_i[0] flipped.
    for (int b = 0; b < 7; b++) pkt[b] = $urandom;
    calc = ref_pkt(7, 0);
    push_exp(calc, 1'b1, 1'b0, 1'b0);
    send_pkt(7, 0, calc);
    push_exp(calc, 1'b0, 1'b0, 1'b0);
    send_pkt(7, 0, calc ^ 32'h1);

    // 3-beat packet, 2 valid bytes on the last beat; upper garbage must not matter.
    for (int b = 0; b < 3; b++) pkt[b] = $urandom;
    calc = ref_pkt(3, 2);
    push_exp(calc, 1'b1, 1'b0, 1'b0);
    send_pkt(3, 2, calc);
    pkt[2][31:16] = pkt[2][31:16] ^ 16'hA5A5;
    push_exp(calc, 1'b1, 1'b0, 1'b0);
    send_pkt(3, 2, calc);

    // Length: 9 beats flags, 8 beats is fine, following 2-beat packet clean.
    for (int b = 0; b < 9; b++) pkt[b] = $urandom;
    calc = ref_pkt(9, 0);
    push_exp(calc, 1'b0, 1'b1, 1'b0);
    send_pkt(9, 0, calc);
    calc = ref_pkt(8, 0);
    push_exp(calc, 1'b1, 1'b0, 1'b0);
    send_pkt(8, 0, calc);
    calc = ref_pkt(2, 0);
    push_exp(calc, 1'b1, 1'b0, 1'b0);
    send_pkt(2, 0, calc);
    wait_drain();

    // sop repeated mid-packet: first two beats are discarded.
    send_beat(1, 0, $urandom, 0, 32'h0);
    send_beat(0, 0, $urandom, 0, 32'h0);
    pkt[0] = $urandom; pkt[1] = $urandom;
    calc = ref_pkt(2, 0);
    push_exp(calc, 1'b0, 1'b0, 1'b1);
    send_pkt(2, 0, calc);

    // Orphan non-eop beat in IDLE taints the next packet.
    send_beat(0, 0, $urandom, 0, 32'h0);
    pkt[0] = $urandom; pkt[1] = $urandom;
    calc = ref_pkt(2, 0);
    push_exp(calc, 1'b0, 1'b0, 1'b1);
    send_pkt(2, 0, calc);
    wait_drain();

    // Orphan eop in IDLE with the result held for 5 cycles.
    rdy_mode = 1;
    push_exp(INIT ^ XOROUT, 1'b0, 1'b0, 1'b1);
    send_beat(0, 1, $urandom, 0, INIT ^ XOROUT);
    repeat (5) @(negedge clk);
    rdy_mode = 0;
    wait_drain();

    // Reset during beat 3 of a packet: no result, next packet clean.
    send_beat(1, 0, $urandom, 0, 32'h0);
    send_beat(0, 0, $urandom, 0, 32'h0);
    s_valid_i = 1'b1; s_eop_i = 1'b1; s_data_i = $urandom; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; s_valid_i = 1'b0; s_eop_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_no_result", {31'h0, res_valid_o}, 32'h0);
      @(negedge clk);
    end
    chk("rst_mid_ready", {31'h0, s_ready_o}, 32'h1);
    for (int b = 0; b < 3; b++) pkt[b] = $urandom;
    calc = ref_pkt(3, 1);
    push_exp(calc, 1'b1, 1'b0, 1'b0);
    send_pkt(3, 1, calc);
    wait_drain();

    // Randomised well-formed traffic with bubbles and random back-pressure.
    bubbles  = 1;
    rdy_mode = 2;
    for (int k = 0; k < 40; k++) begin
      nb   = $urandom_range(1, 10);
      lnb  = $urandom_range(0, 7);
      for (int b = 0; b < nb; b++) pkt[b] = $urandom;
      calc = ref_pkt(nb, lnb);
      flip = ($urandom_range(0, 3) == 0);
      push_exp(calc, !flip && (nb <= MAX_BEATS), nb > MAX_BEATS, 1'b0);
      send_pkt(nb, lnb, flip ? calc ^ (32'h1 << $urandom_range(0, 31)) : calc);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_drain();
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk("all_results_seen", expq.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_lcrc_stream_checker.md
# pcie_lcrc_stream_checker

Streaming, parametrised LCRC checker for the DLL RX path. It accumulates a 32-bit CRC over a multi-beat TLP presented DATA_W bits per clock, with partial final beats. On the end-of-packet beat it compares the accumulated value with the received LCRC. It returns one registered result per packet over a valid/ready handshake, together with length and framing error flags. It sits between the RX framer and the DLL ACK/NAK logic and generalises the fixed-size 224-bit single-cycle check to arbitrary packet lengths, widths and polynomials.

## Interface
- DATA_W, 32, beat width in bits; multiple of 8, 8..256
- POLY, 32'h04C11DB7, generator polynomial
- INIT, 32'hFFFFFFFF, CRC seed loaded at start of packet
- XOROUT, 32'h00000000, XOR applied to final CRC before compare
- MAX_BEATS, 8, maximum legal beats per packet
- NB_W = $clog2(DATA_W/8)+1 (derived)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- s_valid_i  in  1  input beat valid
- s_ready_o  out  1  checker accepts beat
- s_sop_i  in  1  first beat of packet
- s_eop_i  in  1  last beat of packet
- s_data_i  in  DATA_W  payload beat
- s_nbytes_i  in  NB_W  valid bytes on eop beat, taken from bits [8*n-1:0]; 0 means full beat; ignored on non-eop beats
- crc_i  in  32  received LCRC, sampled on accepted eop beat
- res_valid_o  out  1  result available
- res_ready_i  in  1  result consumed
- crc_ok_o  out  1  CRC matched and no error
- crc_calc_o  out  32  computed CRC (after XOROUT)
- len_err_o  out  1  packet exceeded MAX_BEATS
- seq_err_o  out  1  framing violation

## Operation
- Beat accepted when s_valid_i && s_ready_o; s_ready_o = (state != RESULT).
- Per-bit update, bits processed in ascending index order (bit 0 first): fb = crc[31] ^ d; crc = {crc[30:0],1'b0} ^ (fb ? POLY : 0). Whole beat unrolled combinationally in one cycle.
- Byte-lane mask on eop beat: only bits [8*n-1:0] processed, n = s_nbytes_i (0 → DATA_W/8; values > DATA_W/8 saturate to DATA_W/8).
- States: IDLE, BUSY, RESULT.
- IDLE: accepted sop&!eop → seed with INIT, absorb beat, beat_cnt=1, → BUSY. Accepted sop&eop → single-beat result, → RESULT. Accepted beat without sop → dropped, sets pending seq_err; if it also has eop → RESULT with crc_ok_o=0, seq_err_o=1, crc_calc_o=INIT^XOROUT.
- BUSY: accepted beat absorbed, beat_cnt saturating increment; beat_cnt > MAX_BEATS sets len_err. Accepted sop → current packet discarded, reseed with INIT, seq_err set, continue in BUSY (or → RESULT if also eop). Accepted eop → RESULT.
- RESULT: outputs stable while res_valid_o && !res_ready_i; res_ready_i → IDLE, error flags cleared.
- crc_ok_o = (crc_calc_o == crc_i_sampled) && !len_err_o && !seq_err_o.
- beat_cnt width $clog2(MAX_BEATS+2), saturates and never wraps.
- s_valid_i low: no state change, no CRC update (bubbles allowed anywhere).

## Timing
- Reset (rst_n low at clk edge): state=IDLE, res_valid_o=0, crc_ok_o=0, crc_calc_o=0, len_err_o=0, seq_err_o=0, s_ready_o=1 from the first cycle after reset. Reset mid-packet or mid-RESULT discards everything and produces no result.
- Latency: result outputs registered; res_valid_o rises the cycle after the eop beat is accepted.
- Throughput: one beat per clock inside a packet; one bubble cycle per packet minimum (RESULT state), more if res_ready_i is held low.
- res_ready_i may already be high when res_valid_o rises; the handshake completes in that cycle and s_ready_o returns high on the next cycle.
- While in RESULT, s_ready_o=0; the upstream must hold its beat.

## Test plan
- DATA_W=32, single beat sop&eop, data=0, nbytes=1, crc_i=32'h4E08BFB4 → one cycle later res_valid_o=1, crc_calc_o=32'h4E08BFB4, crc_ok_o=1.
- 7-beat 224-bit packet, random data, crc_i from bit-serial golden model → crc_ok_o=1; same packet with crc_i[0] flipped → crc_ok_o=0, crc_calc_o unchanged.
- 3-beat packet with last beat nbytes=2 and garbage in the upper 16 bits → crc_calc_o equals the model over 80 bits; changing the garbage has no effect.
- MAX_BEATS=8, 9-beat packet with correct CRC → len_err_o=1, crc_ok_o=0; a following 2-beat packet → len_err_o=0.
- sop repeated mid-packet, eop beat in IDLE without sop, res_ready_i held low 5 cycles → seq_err_o=1, outputs stable and s_ready_o=0 for all 5 cycles.
- rst_n low for one cycle during beat 3 of a packet → no result; next clean packet checks correctly.
